// File: rtl/audio_rec_play_ctrl_if.sv
// MMIO slot bus for the PDM record/playback controller.
// rd_data is driven combinationally by the slave from addr.
interface audio_rec_play_ctrl_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          cs;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/audio_rec_play_ctrl.sv
// PDM audio path sequencer: records the mic bitstream into a 1-bit buffer
// and plays it back on the speaker output.
module audio_rec_play_ctrl #(
  parameter int unsigned CLK_DIV = 40,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic                        clk,
  input  logic                        reset_n,
  audio_rec_play_ctrl_if.slave        bus,
  output logic                        mic_clk,
  output logic                        mic_lrsel,
  input  logic                        mic_data,
  output logic                        audio_pdm,
  output logic                        audio_on
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned CW    = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] len_reg, len_nxt;
  logic [PW-1:0] rec_len, rec_len_nxt;
  logic          done, done_nxt;
  logic          loop_en, loop_nxt;
  logic          pdm_nxt;
  logic          mic_s1, mic_s;
  logic          mem_we;
  logic          mem_rd;
  logic          tick;
  logic          cmd_wr, len_wr;
  logic          rec_cmd, play_cmd, stop_cmd;
  logic [PW-1:0] len_sat;
  logic [31:0]   rd_mux;
  logic          unused_bus;

  logic mem [DEPTH];

  assign mic_lrsel = 1'b0;
  assign unused_bus = &{1'b0, bus.read, bus.wr_data};

  // Free-running divider; tick is the last low cycle of mic_clk
  assign tick    = (cnt == CW'(CLK_DIV - 1));
  assign cnt_nxt = tick ? '0 : cnt + CW'(1);

  assign cmd_wr   = bus.cs && bus.write && (bus.addr == 5'd0);
  assign len_wr   = bus.cs && bus.write && (bus.addr == 5'd1);
  assign rec_cmd  = cmd_wr && bus.wr_data[0];
  assign play_cmd = cmd_wr && bus.wr_data[1];
  assign stop_cmd = cmd_wr && bus.wr_data[2];
  assign len_sat  = (bus.wr_data[ADDR_W:0] > PW'(DEPTH)) ? PW'(DEPTH)
                                                         : bus.wr_data[ADDR_W:0];
  assign mem_rd   = mem[ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      len_reg   <= '0;
      rec_len   <= '0;
      done      <= 1'b0;
      loop_en   <= 1'b0;
      audio_pdm <= 1'b0;
      audio_on  <= 1'b0;
      mic_clk   <= 1'b1;
      mic_s1    <= 1'b0;
      mic_s     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      len_reg   <= len_nxt;
      rec_len   <= rec_len_nxt;
      done      <= done_nxt;
      loop_en   <= loop_nxt;
      audio_pdm <= pdm_nxt;
      audio_on  <= (state_nxt == PLAY);
      mic_clk   <= (cnt_nxt < CW'(CLK_DIV / 2));
      mic_s1    <= mic_data;
      mic_s     <= mic_s1;
    end
  end

  // Sample buffer has no reset; rec_len gates playback of stale contents
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr[ADDR_W-1:0]] <= mic_s;
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    len_nxt     = len_reg;
    rec_len_nxt = rec_len;
    done_nxt    = done;
    loop_nxt    = loop_en;
    pdm_nxt     = audio_pdm;
    mem_we      = 1'b0;

    if (len_wr) len_nxt  = len_sat;
    if (cmd_wr) loop_nxt = bus.wr_data[3];

    case (state)
      IDLE: begin
        pdm_nxt = 1'b0;
        // record takes priority over play in the same command
        if (rec_cmd) begin
          if (len_reg != '0) begin
            state_nxt = RECORD;
            ptr_nxt   = '0;
            done_nxt  = 1'b0;
          end
        end else if (play_cmd && (rec_len != '0)) begin
          state_nxt = PLAY;
          ptr_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end
      RECORD: begin
        pdm_nxt = 1'b0;
        if (stop_cmd) begin
          state_nxt   = IDLE;
          rec_len_nxt = ptr;
        end else if (tick) begin
          mem_we = 1'b1;
          if (ptr == len_reg - PW'(1)) begin
            state_nxt   = IDLE;
            rec_len_nxt = len_reg;
            done_nxt    = 1'b1;
            ptr_nxt     = '0;
          end else begin
            ptr_nxt = ptr + PW'(1);
          end
        end
      end
      PLAY: begin
        if (stop_cmd) begin
          state_nxt = IDLE;
        end else if (tick) begin
          pdm_nxt = mem_rd;
          if (ptr == rec_len - PW'(1)) begin
            ptr_nxt = '0;
            if (!loop_en) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            ptr_nxt = ptr + PW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      5'd0:    rd_mux = {29'b0, done, state};
      5'd1:    rd_mux = 32'(len_reg);
      5'd2:    rd_mux = 32'(rec_len);
      5'd3:    rd_mux = 32'(ptr);
      default: rd_mux = '0;
    endcase
  end

  assign bus.rd_data = rd_mux;

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Directed bench for audio_rec_play_ctrl with CLK_DIV=4, ADDR_W=4.
module tb_audio_rec_play_ctrl;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic mic_clk, mic_lrsel, mic_data, audio_pdm, audio_on;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  audio_rec_play_ctrl_if bus ();

  audio_rec_play_ctrl #(.CLK_DIV(4), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mic_clk   (mic_clk),
    .mic_lrsel (mic_lrsel),
    .mic_data  (mic_data),
    .audio_pdm (audio_pdm),
    .audio_on  (audio_on)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_phase(input int p);
    while ((cyc % 4) != p) step();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd_data;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs      = 1'b1;
    bus.write   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    step();
    bus.cs      = 1'b0;
    bus.write   = 1'b0;
    bus.wr_data = '0;
  endtask

  initial begin
    rd_vec_t     reset_tab [6];
    rd_vec_t     rec_tab   [4];
    logic        clk_tab   [8];
    logic        bits      [5];
    logic [31:0] d;
    logic        exp_pdm, exp_on;
    int          n;
    bit          seen;

    reset_tab = '{'{5'd0, 32'd0}, '{5'd1, 32'd0}, '{5'd2, 32'd0},
                  '{5'd3, 32'd0}, '{5'd7, 32'd0}, '{5'd31, 32'd0}};
    rec_tab   = '{'{5'd0, 32'd4}, '{5'd1, 32'd5}, '{5'd2, 32'd5}, '{5'd3, 32'd0}};
    clk_tab   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bits      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.wr_data = '0;
    mic_data = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;

    // Reset state and divider pattern
    check("audio_on_rst", 32'(audio_on), 32'd0);
    check("audio_pdm_rst", 32'(audio_pdm), 32'd0);
    check("mic_lrsel", 32'(mic_lrsel), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rd(reset_tab[i].addr, d);
      check($sformatf("rst_rd[%0d]", reset_tab[i].addr), d, reset_tab[i].exp);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mic_clk[%0d]", i), 32'(mic_clk), 32'(clk_tab[i]));
      step();
    end

    // Record 5 samples
    wr(5'd1, 32'd5);
    wait_phase(3);
    mic_data = bits[0];
    wr(5'd0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0) mic_data = bits[i];
        rd(5'd0, d);
        check("rec_state", d, 32'd1);
        step();
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd(rec_tab[i].addr, d);
      check($sformatf("rec_rd[%0d]", rec_tab[i].addr), d, rec_tab[i].exp);
    end

    // Single playback
    wr(5'd0, 32'h2);
    exp_on = 1'b1; exp_pdm = 1'b0; n = 0;
    check("play_on", 32'(audio_on), 32'(exp_on));
    check("play_pdm", 32'(audio_pdm), 32'(exp_pdm));
    while (n < 5) begin
      step();
      if ((cyc % 4) == 0) begin
        exp_pdm = bits[n];
        n++;
        exp_on = (n < 5);
      end
      check("play_pdm", 32'(audio_pdm), 32'(exp_pdm));
      check("play_on", 32'(audio_on), 32'(exp_on));
    end
    step();
    check("play_end_pdm", 32'(audio_pdm), 32'd0);
    check("play_end_on", 32'(audio_on), 32'd0);
    rd(5'd0, d);
    check("play_end_status", d, 32'd4);

    // Looped playback, three full passes, then stop
    wr(5'd0, 32'hA);
    rd(5'd0, d);
    check("loop_status", d, 32'd2);
    exp_pdm = 1'b0; n = 0;
    while (n < 15) begin
      step();
      if ((cyc % 4) == 0) begin
        exp_pdm = bits[n % 5];
        n++;
      end
      check("loop_pdm", 32'(audio_pdm), 32'(exp_pdm));
      check("loop_on", 32'(audio_on), 32'd1);
    end
    wr(5'd0, 32'h4);
    rd(5'd0, d);
    check("stop_status", d, 32'd0);
    check("stop_on", 32'(audio_on), 32'd0);
    step(); step();
    check("stop_pdm", 32'(audio_pdm), 32'd0);

    // Length saturation, then stop after 7 ticks
    wr(5'd1, 32'd31);
    rd(5'd1, d);
    check("len_sat", d, 32'd16);
    wr(5'd1, 32'd16);
    wait_phase(3);
    wr(5'd0, 32'h1);
    repeat (28) step();
    rd(5'd3, d);
    check("ptr7", d, 32'd7);
    wr(5'd0, 32'h4);
    rd(5'd0, d);
    check("stop7_status", d, 32'd0);
    rd(5'd2, d);
    check("stop7_rec_len", d, 32'd7);

    // Stop coincident with the 8th tick
    wait_phase(3);
    wr(5'd0, 32'h1);
    repeat (31) step();
    rd(5'd0, d);
    check("tick8_state", d, 32'd1);
    wr(5'd0, 32'h4);
    rd(5'd2, d);
    check("tick8_rec_len", d, 32'd7);

    // Zero lengths ignore record/play
    wr(5'd0, 32'h1);
    wr(5'd0, 32'h4);
    rd(5'd2, d);
    check("zero_rec_len", d, 32'd0);
    wr(5'd1, 32'd0);
    wr(5'd0, 32'h3);
    rd(5'd0, d);
    check("zero_cmd_status", d, 32'd0);
    repeat (5) step();
    rd(5'd0, d);
    check("zero_cmd_status2", d, 32'd0);

    // Record+play together records; then reset mid-play
    mic_data = 1'b1;
    wr(5'd1, 32'd3);
    wr(5'd0, 32'h3);
    rd(5'd0, d);
    check("recplay_state", d, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      rd(5'd0, d);
      seen = (d == 32'd4);
    end
    check("len3_done", d, 32'd4);
    rd(5'd2, d);
    check("len3_rec_len", d, 32'd3);
    wr(5'd0, 32'h2);
    check("len3_play_on", 32'(audio_on), 32'd1);
    for (int i = 0; i < 20 && audio_pdm !== 1'b1; i++) step();
    check("len3_pdm", 32'(audio_pdm), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_on", 32'(audio_on), 32'd0);
    check("arst_pdm", 32'(audio_pdm), 32'd0);
    check("arst_mic_clk", 32'(mic_clk), 32'd1);
    rd(5'd2, d);
    check("arst_rec_len", d, 32'd0);
    rd(5'd0, d);
    check("arst_status", d, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    repeat (3) step();
    rd(5'd0, d);
    check("post_rst_status", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/audio_rec_play_ctrl.md
Name: audio_rec_play_ctrl

Overview:
- Slot-mapped controller that sequences the board's PDM audio path: captures the PDM microphone bitstream into an on-chip bit buffer, then plays the buffer back on the PDM speaker output.
- Generates the microphone clock and owns the audio_pdm/audio_on outputs, replacing direct software bit-banging of the speaker data and power registers.
- Sits in an MMIO slot; software configures length, issues record/play/stop commands and polls status.

Parameters:
- CLK_DIV, 40, system clocks per mic_clk period (even, >=4); 100 MHz / 40 = 2.5 MHz.
- ADDR_W, 14, buffer address width; DEPTH = 2**ADDR_W one-bit samples.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cs  in  1  slot select
- read  in  1  slot read strobe (no side effects)
- write  in  1  slot write strobe
- addr  in  5  register address
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational from addr
- mic_clk  out  1  PDM microphone clock
- mic_lrsel  out  1  tied 0
- mic_data  in  1  PDM microphone data (asynchronous)
- audio_pdm  out  1  PDM speaker data
- audio_on  out  1  speaker amplifier enable

Behaviour:
- Reset (reset_n low, async): state IDLE, div cnt 0, ptr 0, len_reg 0, rec_len 0, done 0, loop 0, audio_pdm 0, audio_on 0, mic_clk 1, synchroniser cleared.
- Clock divider: cnt counts 0..CLK_DIV-1 and wraps, free-running. mic_clk = 1 when cnt < CLK_DIV/2, else 0. tick = one-cycle pulse when cnt == CLK_DIV-1, i.e. the last low cycle before mic_clk rises.
- mic_data passes through a 2-FF synchroniser (mic_s). Sampling uses mic_s at tick.
- Writes (cs && write):
  - addr 0, CMD: bit0 record, bit1 play, bit2 stop, bit3 loop. The loop value is latched on every CMD write. Record, play and stop are one-cycle pulses, not stored.
  - addr 1, LEN: len_reg = wr_data[ADDR_W:0], saturated to DEPTH.
- Reads (combinational, any addr):
  - addr 0: {29'b0, done, state[1:0]} with IDLE=0, RECORD=1, PLAY=2.
  - addr 1: len_reg.
  - addr 2: rec_len.
  - addr 3: ptr.
  - any other addr: 0.
- FSM transitions:
  - IDLE + record && len_reg != 0: go to RECORD; ptr=0; done=0.
  - IDLE + play && rec_len != 0: go to PLAY; ptr=0; done=0.
  - IDLE, record and play in the same write: record wins. A command with its length == 0 is ignored; state stays IDLE and done is unchanged.
  - RECORD, each tick: mem[ptr] <= mic_s; ptr++. On the tick that writes index len_reg-1: rec_len = len_reg, done = 1, go to IDLE, ptr = 0.
  - PLAY, each tick: read mem[ptr]; audio_pdm takes that bit 1 clk after the tick (synchronous read) and holds it until the next update. ptr++. On the tick reading index rec_len-1: if loop, ptr = 0 and stay in PLAY; else done = 1, go to IDLE.
  - RECORD or PLAY + stop: go to IDLE next clk. In RECORD, rec_len = ptr (samples written so far). done is not set.
  - stop and a tick in the same cycle: stop wins; no sample is written or read.
  - In RECORD or PLAY, record/play commands are ignored. A write to LEN is accepted but affects only the next record.
- Outputs:
  - audio_on = 1 exactly while state == PLAY (registered with the state).
  - audio_pdm is forced to 0 on the clk after leaving PLAY, and is 0 in IDLE and RECORD.
- Width: ptr, len_reg and rec_len are ADDR_W+1 bits so DEPTH itself is representable; no wrap beyond DEPTH-1.
- Reset mid-operation: immediate return to reset values. Buffer contents are undefined afterwards; rec_len = 0 prevents playback of them.

Test Plan:
- Bench params CLK_DIV=4, ADDR_W=4. Release reset -> mic_clk pattern 1,1,0,0 repeating; tick every 4th clk; all status reads 0.
- LEN=5, CMD=record; drive mic_data 1,0,1,1,0 per tick -> state reads 1 for 20 clks, then status done=1/state=0, rec_len=5.
- Then CMD=play (loop=0) -> audio_on=1; audio_pdm sequence 1,0,1,1,0, each change 1 clk after a tick; then audio_on=0, audio_pdm=0, done=1.
- CMD=play|loop(bit3) -> pattern repeats 3 full times with no gap; CMD=stop -> state 0 next clk, done stays 0, audio_on=0.
- LEN=16, record, stop after 7 ticks -> rec_len=7; stop coincident with the 8th tick -> rec_len=7, mem[7] not written.
- CMD with bits0|1 while LEN=0 and rec_len=0 -> stays IDLE. Record+play together with LEN=3 -> RECORD. Assert reset_n low mid-PLAY -> audio_on=0 and audio_pdm=0 asynchronously, rec_len=0.
